// File: rtl/s2a_pkg.sv
// Shared types and AXI constants for the stream-to-AXI write master.
// Block addressing helper keeps the 64 B alignment arithmetic in one place.
package s2a_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } s2a_state_e;

  localparam logic [3:0] LEN16     = 4'hf;
  localparam logic [2:0] SIZE4     = 3'b010;
  localparam logic [1:0] INCR      = 2'b01;
  localparam logic [1:0] OKAY      = 2'b00;
  localparam logic [3:0] STRB_ALL  = 4'hf;
  localparam logic [3:0] LAST_BEAT = 4'hf;

  localparam int BLK_BYTES = 64;
  localparam int BLK_SHIFT = $clog2(BLK_BYTES);
  localparam int BLK_AW    = 32 - BLK_SHIFT;

  // Base (already stripped of its low offset bits) plus block index, re-aligned.
  function automatic logic [31:0] blk_addr(input logic [BLK_AW-1:0] base_blk,
                                           input logic [BLK_AW-1:0] idx);
    logic [BLK_AW-1:0] blk;
    blk = base_blk + idx;
    return {blk, {BLK_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/s2a_controller_if.sv
// AXI write-channel bundle (AW, W, B) between the stream master and the interconnect.
// Handshake rule on every channel: a beat transfers on the rising edge where
// valid and ready are both 1; once valid rises, the source holds it and its
// payload stable until that edge, and ready may toggle freely.
interface s2a_controller_if;

  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/s2a_buffer.sv
// 32x32 ping-pong sample store: synchronous write, asynchronous read.
// No reset on the array so it maps onto distributed RAM.
module s2a_buffer (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata
);

  logic [31:0] mem [32];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/s2a_controller.sv
// Stream-to-AXI write master: fills a 32-word ping-pong buffer and writes each
// completed 16-word half as one INCR burst into a circular OCM window.
module s2a_controller
  import s2a_pkg::*;
#(
  parameter logic [31:0] ocm_haddr = 32'hfffd0000,
  parameter int          ocm_width = 16
) (
  input  logic             AXI_clk,
  input  logic             rst_n,
  input  logic             sync,
  input  logic             Ien,
  input  logic [31:0]      Idata,
  s2a_controller_if.master axi,
  output logic [31:0]      s2a_cnt,
  output logic             s2a_err,
  output s2a_state_e       state
);

  localparam int IDX_W = ocm_width - 6;

  logic [35:0]       cnt;
  logic [1:0]        pending;
  logic [1:0]        pending_nxt;
  logic [31:0]       addr_q [2];
  logic              rd_half;
  logic              flush;
  logic [3:0]        beat;
  logic [31:0]       rd_word;

  logic              wr_en;
  logic              fill_done;
  logic              fill_half;
  logic              resp_done;
  logic              err_set;
  logic [IDX_W-1:0]  blk_idx;
  logic [31:0]       fill_addr;

  // sync drops a word presented in the same cycle.
  assign wr_en     = Ien && !sync;
  assign fill_half = cnt[4];
  assign fill_done = wr_en && (cnt[3:0] == 4'hf);
  assign resp_done = (state == S_RESP) && axi.bvalid && axi.bready;

  assign blk_idx   = cnt[ocm_width-3:4];
  assign fill_addr = blk_addr(ocm_haddr[31:BLK_SHIFT], BLK_AW'(blk_idx));

  assign err_set = (fill_done && pending[fill_half]) ||
                   (resp_done && (axi.bresp != OKAY));

  // A fill setting a flag wins over the burst completion clearing it.
  always_comb begin
    pending_nxt = pending;
    if (resp_done) begin
      pending_nxt[rd_half] = 1'b0;
    end
    if (fill_done) begin
      pending_nxt[fill_half] = 1'b1;
    end
  end

  s2a_buffer u_buf (
    .clk   (AXI_clk),
    .we    (wr_en),
    .waddr (cnt[4:0]),
    .wdata (Idata),
    .raddr ({rd_half, beat}),
    .rdata (rd_word)
  );

  always_ff @(posedge AXI_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      pending   <= '0;
      s2a_err   <= 1'b0;
      addr_q[0] <= '0;
      addr_q[1] <= '0;
    end else if (sync) begin
      cnt     <= '0;
      pending <= '0;
      s2a_err <= 1'b0;
    end else begin
      if (wr_en) begin
        cnt <= cnt + 36'd1;
      end
      if (fill_done) begin
        addr_q[fill_half] <= fill_addr;
      end
      pending <= pending_nxt;
      if (err_set) begin
        s2a_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge AXI_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      axi.awaddr  <= '0;
      axi.awvalid <= 1'b0;
      axi.wvalid  <= 1'b0;
      axi.bready  <= 1'b0;
      beat        <= '0;
      rd_half     <= 1'b0;
      flush       <= 1'b0;
    end else begin
      // Restart during a burst: let it finish, then resume from half 0.
      if (sync && (state != S_IDLE)) begin
        flush <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (sync) begin
            rd_half <= 1'b0;
          end else if (pending[rd_half]) begin
            axi.awaddr  <= addr_q[rd_half];
            axi.awvalid <= 1'b1;
            state       <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (axi.awready) begin
            axi.awvalid <= 1'b0;
            axi.wvalid  <= 1'b1;
            beat        <= '0;
            state       <= S_DATA;
          end
        end
        S_DATA: begin
          if (axi.wready) begin
            beat <= beat + 4'd1;
            if (beat == LAST_BEAT) begin
              axi.wvalid <= 1'b0;
              axi.bready <= 1'b1;
              state      <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (axi.bvalid) begin
            axi.bready <= 1'b0;
            rd_half    <= (flush || sync) ? 1'b0 : ~rd_half;
            flush      <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign axi.awlen   = LEN16;
  assign axi.awsize  = SIZE4;
  assign axi.awburst = INCR;
  assign axi.wstrb   = STRB_ALL;
  assign axi.wdata   = rd_word;
  assign axi.wlast   = axi.wvalid && (beat == LAST_BEAT);

  assign s2a_cnt = cnt[35:4];

endmodule

// File: tb/tb_s2a_controller.sv
// Directed bench for s2a_controller: a negedge monitor collects AXI transfers,
// the main sequence compares them with hand-built expected queues.
module tb_s2a_controller;
  import s2a_pkg::*;

  logic        AXI_clk;
  logic        rst_n;
  logic        sync;
  logic        Ien;
  logic [31:0] Idata;
  logic [31:0] s2a_cnt;
  logic        s2a_err;
  s2a_state_e  dut_state;

  s2a_controller_if axi_if ();

  s2a_controller dut (
    .AXI_clk (AXI_clk),
    .rst_n   (rst_n),
    .sync    (sync),
    .Ien     (Ien),
    .Idata   (Idata),
    .axi     (axi_if),
    .s2a_cnt (s2a_cnt),
    .s2a_err (s2a_err),
    .state   (dut_state)
  );

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_aw_q[$];
  logic [31:0] got_w_q[$];
  logic [31:0] got_aw_q[$];

  int          b_cnt     = 0;
  int          proto_err = 0;
  int          aw_out    = 0;
  logic [3:0]  mon_beat  = '0;
  logic        aw_stall  = 1'b0;
  logic        w_stall   = 1'b0;
  logic [31:0] aw_hold_addr = '0;
  logic [31:0] w_hold_data  = '0;
  logic        w_hold_last  = 1'b0;

  bit stall_mode = 1'b0;
  bit aw_hold    = 1'b0;

  // ---------------- clock ----------------
  initial begin
    AXI_clk = 1'b0;
    forever #5 AXI_clk = ~AXI_clk;
  end

  // ---------------- slave-side ready driver ----------------
  initial begin
    axi_if.awready = 1'b1;
    axi_if.wready  = 1'b1;
    axi_if.bvalid  = 1'b1;
    forever begin
      @(posedge AXI_clk);
      #2;
      axi_if.awready = aw_hold ? 1'b0 : (stall_mode ? 1'($urandom_range(0, 1)) : 1'b1);
      axi_if.wready  = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge AXI_clk) begin
    if (rst_n) begin
      if (aw_stall && (!axi_if.awvalid || axi_if.awaddr !== aw_hold_addr)) proto_err++;
      if (w_stall && (!axi_if.wvalid || axi_if.wdata !== w_hold_data || axi_if.wlast !== w_hold_last)) proto_err++;
      aw_stall     = axi_if.awvalid && !axi_if.awready;
      aw_hold_addr = axi_if.awaddr;
      w_stall      = axi_if.wvalid && !axi_if.wready;
      w_hold_data  = axi_if.wdata;
      w_hold_last  = axi_if.wlast;
      if (axi_if.awvalid && axi_if.awready) begin
        got_aw_q.push_back(axi_if.awaddr);
        aw_out++;
      end
      if (axi_if.wvalid && axi_if.wready) begin
        got_w_q.push_back(axi_if.wdata);
        if (aw_out == 0) proto_err++;
        if (axi_if.wlast !== (mon_beat == 4'hf)) proto_err++;
        if (mon_beat == 4'hf) aw_out--;
        mon_beat = mon_beat + 4'd1;
      end
      if (axi_if.bvalid && axi_if.bready) b_cnt++;
    end
  end

  // ---------------- check helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_sb(input string tag);
    chk({tag, "_aw_count"}, got_aw_q.size(), exp_aw_q.size());
    while (got_aw_q.size() > 0 && exp_aw_q.size() > 0)
      chk({tag, "_awaddr"}, got_aw_q.pop_front(), exp_aw_q.pop_front());
    chk({tag, "_w_count"}, got_w_q.size(), exp_q.size());
    while (got_w_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_wdata"}, got_w_q.pop_front(), exp_q.pop_front());
    got_aw_q.delete();
    got_w_q.delete();
    exp_aw_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] d, input int gap);
    Ien   = 1'b1;
    Idata = d;
    @(posedge AXI_clk);
    #1;
    Ien = 1'b0;
    repeat (gap) begin
      @(posedge AXI_clk);
      #1;
    end
  endtask

  task automatic do_sync();
    sync = 1'b1;
    @(posedge AXI_clk);
    #1;
    sync = 1'b0;
  endtask

  task automatic wait_b(input string tag, input int target);
    int n;
    n = 0;
    while (b_cnt < target && n < 4000) begin
      @(negedge AXI_clk);
      n++;
    end
    chk1({tag, "_b_wait"}, b_cnt >= target, 1'b1);
    repeat (2) @(posedge AXI_clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int b0;
    int n;
    logic [31:0] d;

    rst_n        = 1'b0;
    sync         = 1'b0;
    Ien          = 1'b0;
    Idata        = '0;
    axi_if.bresp = OKAY;

    // Reset state
    repeat (3) @(posedge AXI_clk);
    @(negedge AXI_clk);
    chk1("rst_awvalid", axi_if.awvalid, 1'b0);
    chk1("rst_wvalid",  axi_if.wvalid,  1'b0);
    chk1("rst_wlast",   axi_if.wlast,   1'b0);
    chk1("rst_bready",  axi_if.bready,  1'b0);
    chk("rst_awaddr",   axi_if.awaddr,  32'h0);
    chk("rst_awlen",    32'(axi_if.awlen),   32'hf);
    chk("rst_awsize",   32'(axi_if.awsize),  32'h2);
    chk("rst_awburst",  32'(axi_if.awburst), 32'h1);
    chk("rst_wstrb",    32'(axi_if.wstrb),   32'hf);
    chk("rst_cnt",      s2a_cnt, 32'h0);
    chk1("rst_err",     s2a_err, 1'b0);
    chk("rst_state",    32'(dut_state), 32'(S_IDLE));
    @(posedge AXI_clk);
    #1;
    rst_n = 1'b1;
    @(posedge AXI_clk);
    #1;

    // First block: words 0..15, all ready
    b0 = b_cnt;
    exp_aw_q.push_back(32'hfffd0000);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(32'(i));
      send(32'(i), 0);
    end
    @(negedge AXI_clk);
    chk1("t1_awvalid_lat0", axi_if.awvalid, 1'b0);
    @(negedge AXI_clk);
    chk1("t1_awvalid_lat1", axi_if.awvalid, 1'b1);
    chk("t1_awlen_live", 32'(axi_if.awlen), 32'hf);
    wait_b("t1", b0 + 1);
    check_sb("t1");
    chk("t1_cnt", s2a_cnt, 32'd1);
    chk1("t1_err", s2a_err, 1'b0);
    chk("t1_proto", proto_err, 0);

    // 1025 blocks at half rate: block index wraps after 1024
    do_sync();
    chk("t2_sync_cnt", s2a_cnt, 32'd0);
    b0 = b_cnt;
    for (int k = 0; k < 1025; k++)
      exp_aw_q.push_back(32'hfffd0000 + 32'((k % 1024) * 64));
    for (int i = 0; i < 1025 * 16; i++) begin
      exp_q.push_back(32'(i));
      send(32'(i), 1);
    end
    wait_b("t2", b0 + 1025);
    check_sb("t2");
    chk("t2_cnt", s2a_cnt, 32'd1025);
    chk1("t2_err", s2a_err, 1'b0);
    chk("t2_proto", proto_err, 0);

    // Random AW/W stalls at quarter input rate
    do_sync();
    stall_mode = 1'b1;
    b0 = b_cnt;
    for (int k = 0; k < 4; k++)
      exp_aw_q.push_back(32'hfffd0000 + 32'(k * 64));
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      exp_q.push_back(d);
      send(d, 3);
    end
    wait_b("t3", b0 + 4);
    stall_mode = 1'b0;
    check_sb("t3");
    chk("t3_proto", proto_err, 0);
    chk1("t3_err", s2a_err, 1'b0);

    // Overrun: AW blocked while both halves and a third fill complete
    do_sync();
    aw_hold = 1'b1;
    @(posedge AXI_clk);
    #1;
    b0 = b_cnt;
    for (int i = 0; i < 47; i++) send(32'(i), 0);
    @(negedge AXI_clk);
    chk1("t4_err_before", s2a_err, 1'b0);
    chk("t4_state_addr", 32'(dut_state), 32'(S_ADDR));
    send(32'd47, 0);
    @(negedge AXI_clk);
    chk1("t4_err_on_edge", s2a_err, 1'b1);
    repeat (10) @(posedge AXI_clk);
    #1;
    aw_hold = 1'b0;
    wait_b("t4", b0 + 2);
    chk1("t4_err_sticky", s2a_err, 1'b1);
    got_aw_q.delete();
    got_w_q.delete();

    // Error response on first burst, next burst still issued, sync clears
    do_sync();
    chk1("t5_sync_err", s2a_err, 1'b0);
    axi_if.bresp = 2'b10;
    b0 = b_cnt;
    exp_aw_q.push_back(32'hfffd0000);
    exp_aw_q.push_back(32'hfffd0040);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(32'h500 + 32'(i));
      send(32'h500 + 32'(i), 0);
    end
    n = 0;
    while (!axi_if.bready && n < 200) begin
      @(negedge AXI_clk);
      n++;
    end
    chk1("t5_bready_seen", axi_if.bready, 1'b1);
    @(posedge AXI_clk);
    #1;
    axi_if.bresp = OKAY;
    @(negedge AXI_clk);
    chk1("t5_err_slverr", s2a_err, 1'b1);
    @(posedge AXI_clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(32'h600 + 32'(i));
      send(32'h600 + 32'(i), 0);
    end
    wait_b("t5", b0 + 2);
    check_sb("t5");
    chk("t5_cnt", s2a_cnt, 32'd2);
    chk1("t5_err_kept", s2a_err, 1'b1);
    do_sync();
    chk1("t5_err_cleared", s2a_err, 1'b0);
    chk("t5_cnt_cleared", s2a_cnt, 32'd0);

    // sync during DATA: burst completes, next burst restarts at half 0
    b0 = b_cnt;
    for (int i = 0; i < 16; i++) send(32'h700 + 32'(i), 0);
    n = 0;
    while (!axi_if.wvalid && n < 200) begin
      @(negedge AXI_clk);
      n++;
    end
    repeat (3) @(posedge AXI_clk);
    #1;
    chk("t6_state_data", 32'(dut_state), 32'(S_DATA));
    do_sync();
    wait_b("t6a", b0 + 1);
    chk("t6_beats", got_w_q.size(), 16);
    chk("t6_aw_count", got_aw_q.size(), 1);
    chk("t6_cnt", s2a_cnt, 32'd0);
    got_aw_q.delete();
    got_w_q.delete();
    // word presented together with sync is dropped
    Ien   = 1'b1;
    Idata = 32'hdead;
    do_sync();
    Ien = 1'b0;
    exp_aw_q.push_back(32'hfffd0000);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(32'h800 + 32'(i));
      send(32'h800 + 32'(i), 0);
    end
    wait_b("t6b", b0 + 2);
    check_sb("t6");
    chk("t6_cnt_after", s2a_cnt, 32'd1);
    chk("t6_proto", proto_err, 0);
    chk1("t6_err", s2a_err, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
